fir_stream_sink: RTL

FIR_STREAM_SINK -- requirements
Module: fir_stream_sink

---
 rtl/fir_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/fir_stream_sink.sv | 107 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the fir_16tap datapath and its stream sink.
// Q1.15 limits, sample width and the default pipeline latency live here.
package fir_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int DEFAULT_LATENCY = 9;
  localparam int CNT_W           = 16;

  localparam logic signed [SAMPLE_W-1:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] Q15_MIN = 16'sh8000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } sink_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic is_q15_limit(input sample_t s);
    return (s == Q15_MAX) || (s == Q15_MIN);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output.
// Pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [AW:0]      w_rd_next;
  logic             w_bypass;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;
  assign dout  = r_dout;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop_ok};

  // The incoming word becomes the head when it lands in the slot being exposed.
  assign w_bypass  = w_push_ok && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0]);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      r_rd_ptr <= w_rd_next;
      if (w_push_ok || w_pop_ok) begin
        r_dout <= w_bypass ? din : r_mem[w_rd_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/fir_stream_sink.sv
// Captures fir_16tap output once the filter pipeline has filled, buffers it
// in a FIFO for a ready/valid consumer, and keeps drop/saturation statistics.
module fir_stream_sink
  import fir_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [SAMPLE_W-1:0]  y_in,
  output logic                        m_valid,
  output logic signed [SAMPLE_W-1:0]  m_data,
  input  logic                        m_ready,
  input  logic                        clr_stats,
  output logic                        overflow,
  output logic [CNT_W-1:0]            drop_count,
  output logic [CNT_W-1:0]            sat_count,
  output logic [$clog2(DEPTH):0]      level
);

  // state     | meaning
  // ST_WARMUP | counting enable strobes until the filter output is valid
  // ST_RUN    | every enable strobe captures one y_in sample

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LATENCY - 1);

  sink_state_t      r_state;
  logic [CW-1:0]    r_warm_cnt;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_sat_cnt;

  logic                w_capture;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;
  logic [SAMPLE_W-1:0] w_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_WARMUP;
      r_warm_cnt <= '0;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          if (enable) begin
            r_warm_cnt <= r_warm_cnt + CW'(1);
            if (r_warm_cnt == LAT_LAST) begin
              r_state <= ST_RUN;
            end
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // The strobe that completes warm-up is still in WARMUP, so it never captures.
  assign w_capture = enable && (r_state == ST_RUN);
  assign w_drop    = w_capture && w_full && !m_ready;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_capture),
    .pop   (m_ready),
    .din   (y_in),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign m_valid = !w_empty;
  assign m_data  = w_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_sat_cnt  <= '0;
    end else if (clr_stats) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_sat_cnt  <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
      if (w_capture && is_q15_limit(y_in)) begin
        r_sat_cnt <= sat_inc(r_sat_cnt);
      end
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;
  assign sat_count  = r_sat_cnt;

endmodule
